// File: rtl/data_memory.sv
// data_memory: 2**INDEX_BIT-entry register file of WIDTH x WIDTH matrices of 32-bit words,
// one synchronous write port and two combinational read ports. Define DATA_MEMORY_BYPASS_EN
// to forward write_data to any read port addressing the entry being written in that cycle.
module data_memory #(
  parameter int WIDTH     = 4,
  parameter int INDEX_BIT = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       write_enable,
  input  logic [INDEX_BIT-1:0]       read1,
  input  logic [INDEX_BIT-1:0]       read2,
  input  logic [INDEX_BIT-1:0]       write,
  input  logic [WIDTH*WIDTH*32-1:0]  write_data,
  output logic [WIDTH*WIDTH*32-1:0]  data1,
  output logic [WIDTH*WIDTH*32-1:0]  data2
);

  localparam int MAT_BITS = WIDTH * WIDTH * 32;
  localparam int DEPTH    = 2 ** INDEX_BIT;

  logic [MAT_BITS-1:0] mem_q [DEPTH];
  logic [MAT_BITS-1:0] mem_d [DEPTH];

  always_comb begin
    // NOTE: next-state starts as a full copy of the current state so no path leaves mem_d unassigned (no latch).
    mem_d = mem_q;
    if (write_enable) begin
      mem_d[write] = write_data;
    end
  end

  // NOTE: this storage is deliberately reset (every entry reads 0 while RST is low), so it maps to flops, not a RAM macro.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef DATA_MEMORY_BYPASS_EN
  // Each port forwards independently; reset wins so the outputs read 0 with no clock.
  always_comb begin
    data1 = mem_q[read1];
    data2 = mem_q[read2];
    if (!RST) begin
      data1 = '0;
      data2 = '0;
    end else if (write_enable) begin
      if (read1 == write) data1 = write_data;
      if (read2 == write) data2 = write_data;
    end
  end
`else
  assign data1 = mem_q[read1];
  assign data2 = mem_q[read2];
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected read data computed from an
// array model; an independent monitor pops each entry and compares both read ports.
module tb_data_memory;

  localparam int WIDTH     = 4;
  localparam int INDEX_BIT = 3;
  localparam int NW        = WIDTH * WIDTH;
  localparam int MB        = NW * 32;
  localparam int DEPTH     = 2 ** INDEX_BIT;

  logic                 CLK = 1'b0;
  logic                 clk_en = 1'b1;
  logic                 RST;
  logic                 write_enable;
  logic [INDEX_BIT-1:0] read1, read2, write;
  logic [MB-1:0]        write_data;
  logic [MB-1:0]        data1, data2;

  data_memory #(.WIDTH(WIDTH), .INDEX_BIT(INDEX_BIT)) dut (
    .CLK(CLK), .RST(RST), .write_enable(write_enable),
    .read1(read1), .read2(read2), .write(write),
    .write_data(write_data), .data1(data1), .data2(data2)
  );

  // Clock can be parked low so asynchronous-reset reads are checked with no edge at all.
  always #5 CLK = clk_en ? ~CLK : 1'b0;

  typedef struct {
    string         name;
    logic [MB-1:0] e1;
    logic [MB-1:0] e2;
  } exp_t;

  exp_t          exp_q[$];
  logic [MB-1:0] ref_mem [DEPTH];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: the read ports are combinational, so a pushed expectation is a presented output.
  initial begin
    exp_t it;
    forever begin
      wait (exp_q.size() > 0);
      #1;
      it = exp_q.pop_front();
      check({it.name, ".data1"}, data1, it.e1);
      check({it.name, ".data2"}, data2, it.e2);
    end
  end

  function automatic logic [MB-1:0] fill(input logic [31:0] w);
    return {NW{w}};
  endfunction

  function automatic logic [MB-1:0] model_read(input logic [INDEX_BIT-1:0] idx);
    if (!RST) return '0;
`ifdef DATA_MEMORY_BYPASS_EN
    if (write_enable && idx == write) return write_data;
`endif
    return ref_mem[idx];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Drive read indices, push the model's answer, leave the monitor time to sample.
  task automatic expect_read(input string name, input int r1, input int r2);
    exp_t it;
    read1 = INDEX_BIT'(r1);
    read2 = INDEX_BIT'(r2);
    it.name = name;
    it.e1   = model_read(read1);
    it.e2   = model_read(read2);
    exp_q.push_back(it);
    #2;
  endtask

  // One clock with the given write inputs; the model applies the write at the edge.
  task automatic clock_write(input logic we, input int idx, input logic [MB-1:0] d);
    write_enable = we;
    write        = INDEX_BIT'(idx);
    write_data   = d;
    @(posedge CLK);
    if (we && RST) ref_mem[idx] = d;
    @(negedge CLK);
    write_enable = 1'b0;
  endtask

  function automatic logic [MB-1:0] rand_mat();
    logic [MB-1:0] m;
    for (int k = 0; k < NW; k++) m[k*32 +: 32] = $urandom;
    return m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [MB-1:0] m;
    RST = 1'b0; write_enable = 1'b0; read1 = '0; read2 = '0; write = '0; write_data = '0;
    clear_model();

    // Reset state, and a write attempted while reset is held.
    @(negedge CLK);
    expect_read("reset_0_7", 0, 7);
    clock_write(1'b1, 2, fill(32'hCAFEF00D));
    expect_read("write_in_reset", 2, 3);
    RST = 1'b1;

    // Entry 3 with element (r,c) = 16r+c, packed row-major, (0,0) most significant.
    m = '0;
    for (int r = 0; r < WIDTH; r++)
      for (int c = 0; c < WIDTH; c++)
        m[(NW - 1 - (r*WIDTH + c))*32 +: 32] = 32'(16*r + c);
    clock_write(1'b1, 3, m);
    expect_read("entry3_pattern", 3, 3);
    check("entry3_msw", data1[MB-1 -: 32], 32'h0000_0000);
    check("entry3_lsw", data1[31:0], 32'h0000_0033);

    // Two entries read on separate ports, untouched entry still zero.
    clock_write(1'b1, 5, fill(32'hDEADBEEF));
    clock_write(1'b1, 2, fill(32'h12345678));
    expect_read("dual_5_2", 5, 2);
    expect_read("entry0_zero", 0, 0);

    // write_enable low for three clocks must not touch entry 1.
    for (int i = 0; i < 3; i++) clock_write(1'b0, 1, fill(32'hFFFFFFFF));
    expect_read("we_low_entry1", 1, 1);

    // Same-cycle write and read of entry 4: old value (or forwarded) before, new after.
    clock_write(1'b1, 4, rand_mat());
    write_enable = 1'b1; write = 3'd4; write_data = fill(32'hA5A5A5A5);
    expect_read("rw4_before_edge", 4, 5);
    @(posedge CLK);
    ref_mem[4] = fill(32'hA5A5A5A5);
    @(negedge CLK);
    write_enable = 1'b0;
    expect_read("rw4_after_edge", 4, 4);

    // Back-to-back writes to one index keep the last value.
    clock_write(1'b1, 6, rand_mat());
    clock_write(1'b1, 6, rand_mat());
    expect_read("last_write_wins", 6, 6);

    // Randomized traffic, read and write in the same cycle.
    for (int n = 0; n < 200; n++) begin
      write_enable = 1'($urandom_range(0, 1));
      write        = INDEX_BIT'($urandom);
      write_data   = rand_mat();
      if ($urandom_range(0, 3) == 0) begin
        read1 = INDEX_BIT'($urandom);
        read2 = read1;
      end
      expect_read("random", $urandom_range(0, DEPTH-1),
                  ($urandom_range(0, 3) == 0) ? int'(write) : $urandom_range(0, DEPTH-1));
      @(posedge CLK);
      if (write_enable) ref_mem[write] = write_data;
      @(negedge CLK);
    end
    write_enable = 1'b0;

    // Mid-run async reset with the clock parked: all entries read 0 at once.
    clk_en = 1'b0;
    #1;
    RST = 1'b0;
    clear_model();
    for (int i = 0; i < DEPTH; i++) expect_read("async_reset", i, DEPTH - 1 - i);
    RST = 1'b1;
    clk_en = 1'b1;
    @(negedge CLK);

    // Reset falling at the same instant as a write edge loses the write.
    clock_write(1'b1, 6, fill(32'h0BADBEEF));
    expect_read("pre_race_6", 6, 1);
    write_enable = 1'b1; write = 3'd6; write_data = fill(32'h13572468);
    @(posedge CLK);
    RST = 1'b0;
    clear_model();
    @(negedge CLK);
    write_enable = 1'b0;
    expect_read("race_in_reset", 6, 0);
    RST = 1'b1;
    expect_read("race_after_release", 6, 6);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter WIDTH, default 4: matrix dimension; each entry is a WIDTH x WIDTH matrix of 32-bit words.
REQ-002 Parameter INDEX_BIT, default 3: entry index width; depth is 2**INDEX_BIT entries.
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 write_enable  input  1  high commits write_data into entry `write` at the next rising CLK.
REQ-006 read1  input  INDEX_BIT  index for read port 1.
REQ-007 read2  input  INDEX_BIT  index for read port 2.
REQ-008 write  input  INDEX_BIT  index for the write port.
REQ-009 write_data  input  WIDTH*WIDTH*32  matrix to store.
REQ-010 data1  output  WIDTH*WIDTH*32  matrix at entry read1.
REQ-011 data2  output  WIDTH*WIDTH*32  matrix at entry read2.

Function
REQ-012 Matrix bus packing SHALL be row-major with element (0,0) in the most significant word; element (r,c) occupies bits [(WIDTH*WIDTH-1-(r*WIDTH+c))*32 +: 32].
REQ-013 Storage SHALL be 2**INDEX_BIT independent entries, each WIDTH*WIDTH*32 bits.
REQ-014 Read ports SHALL be combinational, with zero-cycle latency from read1/read2 or stored contents to data1/data2.
REQ-015 Both read ports SHALL operate independently; read1 == read2 SHALL return identical data on both ports.
REQ-016 On a rising CLK with write_enable=1 and RST=1, entry `write` SHALL take write_data in full; all other entries are unchanged.
REQ-017 With write_enable=0, no entry SHALL change.
REQ-018 Partial-matrix writes are not supported; a write always replaces all WIDTH*WIDTH words.
REQ-019 Without bypass (see REQ-024), a read of the index being written in the same cycle SHALL return the old contents until the clock edge, and the new contents after it.
REQ-020 Writes to consecutive cycles to the same index SHALL leave the last-written value.
REQ-021 Index values SHALL wrap naturally within INDEX_BIT bits; there are no out-of-range indices.

Reset
REQ-022 RST=0 SHALL asynchronously clear every word of every entry to 0, so data1/data2 read 0 for all indices with no clock required.
REQ-023 While RST=0, writes SHALL be ignored; the first write SHALL occur at the first rising CLK after RST returns high.

Configuration
REQ-024 Macro DATA_MEMORY_BYPASS_EN: when defined, a read port whose index equals `write` while write_enable=1 SHALL output write_data combinationally in the same cycle, with each port evaluated independently and RST=0 overriding it to 0. When undefined, REQ-019 applies and there is no forwarding logic.

Verification
REQ-025 RST=0 asserted mid-run with entries holding nonzero data -> data1/data2 read 0 for all 8 indices immediately, before any CLK edge.
REQ-026 Write entry 3 with element (r,c) = 16*r+c, then read1=3 -> data1 most significant word 0x00000000, least significant word 0x00000033 (element (3,3)).
REQ-027 Write entry 5 = all 0xDEADBEEF and entry 2 = all 0x12345678, then read1=5 and read2=2 in the same cycle -> both values are correct, and entry 0 still reads 0.
REQ-028 write_enable=0 with write=1 and write_data all 0xFFFFFFFF over 3 clocks -> entry 1 stays 0.
REQ-029 Same-cycle write and read of index 4 with new value 0xA5A5A5A5 -> before the edge, data1 shows the old value (or 0xA5A5A5A5 with DATA_MEMORY_BYPASS_EN); after the edge, data1 shows 0xA5A5A5A5.
REQ-030 RST=0 asserted coincident with a write CLK edge -> the entry reads 0, and the write is lost.
